// File: rtl/axi4_clint_mh_if.sv
// AXI4 bus bundle used by the CLINT: 32-bit address/data, 4-bit IDs.
// Only single-beat transfers are carried; the len fields exist for bus compatibility.
interface axi4_interface;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awid, awaddr, awlen, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

  modport master (
    output awid, awaddr, awlen, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );
endinterface

// File: rtl/axi4_clint_mh.sv
// Multi-hart CLINT on an AXI4 slave: prescaled 64-bit mtime, per-hart mtimecmp/msip,
// registered mtip compare. Single-beat reads and writes with byte strobes.
module axi4_clint_mh #(
  parameter int          NUM_HARTS = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          TICK_DIV  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  axi4_interface.slave         clint,
  output logic [NUM_HARTS-1:0] msip,
  output logic [NUM_HARTS-1:0] mtip,
  output logic                 dbg_rd_state,
  output logic                 dbg_wr_state
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {K_NONE, K_MSIP, K_CMP, K_TIME} kind_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;
  typedef enum logic {W_IDLE, W_RESP} wr_state_t;

  rd_state_t   rd_state;
  wr_state_t   wr_state;
  logic [PW-1:0] presc;
  logic        tick;
  logic [63:0] mtime, mtime_inc;
  logic [63:0] mtimecmp [NUM_HARTS];

  logic        arready_q, rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [3:0]  rid_q;
  logic        awready_q, wready_q, bvalid_q;
  logic [1:0]  bresp_q;
  logic [3:0]  bid_q;
  logic        aw_done, w_done;
  logic [31:0] aw_addr, w_data;
  logic [3:0]  aw_id, w_strb;

  kind_t       rd_kind, wr_kind;
  logic [31:0] rd_off, wr_off, rd_val;
  logic        wr_en;
  logic        unused;

  function automatic kind_t dec_kind(input logic [31:0] addr);
    logic [31:0] off;
    kind_t k;
    off = addr - BASE_ADDR;
    k = K_NONE;
    if (off[31:16] == 16'h0) begin
      if (off[15:14] == 2'b00 && 32'(off[13:2]) < NUM_HARTS) k = K_MSIP;
      else if (off[15:14] == 2'b01 && 32'(off[13:3]) < NUM_HARTS) k = K_CMP;
      else if (off[15:3] == 13'h17FF) k = K_TIME;
    end
    return k;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return res;
  endfunction

  // Handshake rule on every channel: a transfer happens on the rising edge where valid and
  // ready are both high; a source holds valid and payload stable until that edge.
  assign clint.arready = arready_q;
  assign clint.rvalid  = rvalid_q;
  assign clint.rdata   = rdata_q;
  assign clint.rresp   = rresp_q;
  assign clint.rid     = rid_q;
  assign clint.rlast   = rvalid_q;
  assign clint.awready = awready_q;
  assign clint.wready  = wready_q;
  assign clint.bvalid  = bvalid_q;
  assign clint.bresp   = bresp_q;
  assign clint.bid     = bid_q;
  assign dbg_rd_state  = rd_state;
  assign dbg_wr_state  = wr_state;

  assign tick      = (presc == PW'(TICK_DIV - 1));
  assign mtime_inc = mtime + {63'b0, tick};
  assign wr_en     = (wr_state == W_IDLE) && aw_done && w_done;
  assign unused    = ^{clint.awlen, clint.arlen, clint.wlast, rd_off, wr_off};

  always_comb begin
    rd_kind = dec_kind(clint.araddr);
    rd_off  = clint.araddr - BASE_ADDR;
    wr_kind = dec_kind(aw_addr);
    wr_off  = aw_addr - BASE_ADDR;
    rd_val  = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (rd_kind == K_MSIP && rd_off[5:2] == 4'(h)) rd_val = {31'b0, msip[h]};
      if (rd_kind == K_CMP && rd_off[6:3] == 4'(h))
        rd_val = rd_off[2] ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
    end
    if (rd_kind == K_TIME) rd_val = rd_off[2] ? mtime[63:32] : mtime[31:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      rid_q     <= '0;
    end else begin
      case (rd_state)
        R_IDLE: if (clint.arvalid && arready_q) begin
          rd_state  <= R_DATA;
          rid_q     <= clint.arid;
          rdata_q   <= rd_val;
          rresp_q   <= (rd_kind == K_NONE) ? DECERR : OKAY;
          rvalid_q  <= 1'b1;
          arready_q <= 1'b0;
        end
        R_DATA: if (clint.rready) begin
          rd_state  <= R_IDLE;
          rvalid_q  <= 1'b0;
          arready_q <= 1'b1;
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // AW and W are captured independently; the write commits one edge after both are held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state  <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      bid_q     <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      aw_addr   <= '0;
      aw_id     <= '0;
      w_data    <= '0;
      w_strb    <= '0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (clint.awvalid && awready_q) begin
            aw_done   <= 1'b1;
            awready_q <= 1'b0;
            aw_addr   <= clint.awaddr;
            aw_id     <= clint.awid;
          end
          if (clint.wvalid && wready_q) begin
            w_done   <= 1'b1;
            wready_q <= 1'b0;
            w_data   <= clint.wdata;
            w_strb   <= clint.wstrb;
          end
          if (wr_en) begin
            wr_state <= W_RESP;
            bvalid_q <= 1'b1;
            bid_q    <= aw_id;
            bresp_q  <= (wr_kind == K_NONE) ? DECERR : OKAY;
          end
        end
        W_RESP: if (clint.bready) begin
          wr_state  <= W_IDLE;
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          wready_q  <= 1'b1;
          aw_done   <= 1'b0;
          w_done    <= 1'b0;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      mtime <= '0;
      msip  <= '0;
      mtip  <= '0;
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      mtime <= mtime_inc;
      // Written mtime bytes override the tick; the other bytes keep the incremented value.
      if (wr_en && wr_kind == K_TIME) begin
        if (wr_off[2]) mtime[63:32] <= merge(mtime_inc[63:32], w_data, w_strb);
        else           mtime[31:0]  <= merge(mtime_inc[31:0], w_data, w_strb);
      end
      for (int h = 0; h < NUM_HARTS; h++) begin
        mtip[h] <= (mtime >= mtimecmp[h]);
        if (wr_en && wr_kind == K_MSIP && wr_off[5:2] == 4'(h) && w_strb[0])
          msip[h] <= w_data[0];
        if (wr_en && wr_kind == K_CMP && wr_off[6:3] == 4'(h)) begin
          if (wr_off[2]) mtimecmp[h][63:32] <= merge(mtimecmp[h][63:32], w_data, w_strb);
          else           mtimecmp[h][31:0]  <= merge(mtimecmp[h][31:0], w_data, w_strb);
        end
      end
    end
  end
endmodule

// File: tb/tb_axi4_clint_mh.sv
// Directed bench for axi4_clint_mh with two harts and a divide-by-4 tick.
module tb_axi4_clint_mh;
  localparam int NH = 2;
  localparam logic [31:0] BASE = 32'h0200_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NH-1:0] msip, mtip;
  logic          dbg_rd_state, dbg_wr_state;
  int            checks = 0;
  int            failures = 0;
  int            cyc;
  logic [31:0]   exp_q[$];

  axi4_interface bus();

  axi4_clint_mh #(.NUM_HARTS(NH), .BASE_ADDR(BASE), .TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .clint(bus), .msip(msip), .mtip(mtip),
    .dbg_rd_state(dbg_rd_state), .dbg_wr_state(dbg_wr_state)
  );

  // clock / reset-relative cycle counter
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, output logic [31:0] data,
                          output logic [1:0] resp, output logic [3:0] rid, output logic last);
    int n;
    int lat;
    @(negedge clk);
    bus.araddr = addr; bus.arid = id; bus.arlen = 8'd0; bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    lat = 0;
    while (!bus.rvalid && n < 50) begin @(negedge clk); n++; lat++; end
    check("rd_timeout", 64'(n < 50), 1);
    check("rd_latency", 64'(lat), 0);
    data = bus.rdata; resp = bus.rresp; rid = bus.rid; last = bus.rlast;
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [3:0] id, output logic [1:0] resp, output logic [3:0] bid);
    int n;
    logic aw_hs, w_hs;
    @(negedge clk);
    bus.awaddr = addr; bus.awid = id; bus.awlen = 8'd0; bus.awvalid = 1'b1;
    bus.wdata = data; bus.wstrb = strb; bus.wlast = 1'b1; bus.wvalid = 1'b1;
    n = 0;
    while ((bus.awvalid || bus.wvalid) && n < 50) begin
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      @(negedge clk); n++;
      if (aw_hs) bus.awvalid = 1'b0;
      if (w_hs)  bus.wvalid = 1'b0;
    end
    bus.bready = 1'b1;
    while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
    check("wr_timeout", 64'(n < 50), 1);
    resp = bus.bresp; bid = bus.bid;
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  // scoreboard front ends: expected values queued, then popped against the observed data
  task automatic rd_expect(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                           input logic [1:0] exp_resp);
    logic [31:0] d;
    logic [1:0]  r;
    logic [3:0]  id, id_o;
    logic        l;
    id = 4'($urandom_range(0, 15));
    exp_q.push_back(exp);
    axi_read(addr, id, d, r, id_o, l);
    check({tag, "_data"}, d, exp_q.pop_front());
    check({tag, "_rresp"}, r, exp_resp);
    check({tag, "_rid"}, id_o, id);
    check({tag, "_rlast"}, l, 1);
  endtask

  task automatic wr_expect(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp);
    logic [1:0] r;
    logic [3:0] id, id_o;
    id = 4'($urandom_range(0, 15));
    axi_write(addr, data, strb, id, r, id_o);
    check({tag, "_bresp"}, r, exp_resp);
    check({tag, "_bid"}, id_o, id);
  endtask

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [3:0]  id_o;
    logic        l;
    int          n;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_ready", {bus.arready, bus.awready, bus.wready}, 3'b111);
    check("rst_valid", {bus.rvalid, bus.bvalid}, 2'b00);
    check("rst_rdata", bus.rdata, 0);
    check("rst_irq", {msip, mtip}, 4'b0000);
    check("rst_fsm", {dbg_rd_state, dbg_wr_state}, 2'b00);
    rst = 1'b1;

    rd_expect("cmp0_lo", BASE + 32'h4000, 32'hFFFF_FFFF, 2'b00);
    rd_expect("cmp0_hi", BASE + 32'h4004, 32'hFFFF_FFFF, 2'b00);
    rd_expect("msip0", BASE, 32'h0, 2'b00);

    // free-running timer: mtime = cycles / 4
    while (cyc < 40) @(negedge clk);
    axi_read(BASE + 32'hBFF8, 4'h3, d, r, id_o, l);
    check("mtime_run", 64'(d >= 9 && d <= 10), 1);

    // timer interrupt on hart 1 only; mtime hits 0x20 on edge 128, mtip follows on 129
    wr_expect("cmp1_lo", BASE + 32'h4008, 32'h20, 4'hF, 2'b00);
    wr_expect("cmp1_hi", BASE + 32'h400C, 32'h0, 4'hF, 2'b00);
    check("mtip_early", mtip, 2'b00);
    while (!mtip[1] && cyc < 400) @(negedge clk);
    check("mtip_cycle", 64'(cyc), 129);
    check("mtip_val", mtip, 2'b10);
    wr_expect("cmp1_hi1", BASE + 32'h400C, 32'h1, 4'hF, 2'b00);
    @(negedge clk);
    check("mtip_clear", mtip, 2'b00);

    // msip strobes
    wr_expect("msip1_lane1", BASE + 32'h4, 32'h1, 4'b0010, 2'b00);
    @(negedge clk);
    check("msip_nolane", msip, 2'b00);
    wr_expect("msip1_lane0", BASE + 32'h4, 32'h1, 4'b0001, 2'b00);
    @(negedge clk);
    check("msip_set", msip, 2'b10);
    rd_expect("msip1_rd", BASE + 32'h4, 32'h1, 2'b00);
    wr_expect("msip1_clr", BASE + 32'h4, 32'h0, 4'hF, 2'b00);
    @(negedge clk);
    check("msip_clr", msip, 2'b00);

    // W three cycles ahead of AW, then a stalled B channel
    @(negedge clk);
    bus.wdata = 32'h1; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.wvalid = 1'b0;
    check("early_w_wready", bus.wready, 0);
    check("early_w_awready", bus.awready, 1);
    repeat (2) @(negedge clk);
    bus.awaddr = BASE; bus.awid = 4'h9; bus.awvalid = 1'b1; bus.bready = 1'b0;
    @(negedge clk);
    bus.awvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 20) begin @(negedge clk); n++; end
    check("late_aw_timeout", 64'(n < 20), 1);
    for (int i = 0; i < 5; i++) begin
      check("b_hold_valid", bus.bvalid, 1);
      check("b_hold_bid", bus.bid, 4'h9);
      check("b_hold_ready", {bus.awready, bus.wready}, 2'b00);
      @(negedge clk);
    end
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("b_single", bus.bvalid, 0);
      @(negedge clk);
    end
    check("b_ready_back", {bus.awready, bus.wready}, 2'b11);
    check("msip_order", msip, 2'b01);

    // unmapped write changes nothing
    wr_expect("unmapped_wr", BASE + 32'h8000, 32'h0, 4'hF, 2'b11);
    @(negedge clk);
    check("msip_unmapped", msip, 2'b01);
    wr_expect("msip0_clr", BASE, 32'h0, 4'hF, 2'b00);

    // mtime carry into the high word
    wr_expect("mtime_hi", BASE + 32'hBFFC, 32'h0, 4'hF, 2'b00);
    wr_expect("mtime_lo", BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF, 2'b00);
    repeat (10) @(negedge clk);
    rd_expect("mtime_wrap_hi", BASE + 32'hBFFC, 32'h1, 2'b00);
    axi_read(BASE + 32'hBFF8, 4'h2, d, r, id_o, l);
    check("mtime_wrap_lo", 64'(d < 8), 1);

    // unmapped read
    rd_expect("decerr", BASE + 32'h8000, 32'h0, 2'b11);

    // R channel held while rready is low
    @(negedge clk);
    bus.araddr = BASE + 32'h4000; bus.arid = 4'h5; bus.arvalid = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("r_hold_valid", bus.rvalid, 1);
      check("r_hold_data", bus.rdata, 32'hFFFF_FFFF);
      check("r_hold_rid", bus.rid, 4'h5);
      check("r_hold_arready", bus.arready, 0);
      check("r_hold_fsm", dbg_rd_state, 1);
      @(negedge clk);
    end
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    check("r_done", {bus.rvalid, bus.arready}, 2'b01);

    // reset mid-read
    @(negedge clk);
    bus.araddr = BASE + 32'hBFF8; bus.arid = 4'h7; bus.arvalid = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("pre_rst_rvalid", bus.rvalid, 1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_rvalid", bus.rvalid, 0);
    check("rst_mid_arready", bus.arready, 1);
    check("rst_mid_rdata", bus.rdata, 0);
    @(negedge clk);
    rst = 1'b1;
    rd_expect("post_rst_cmp1", BASE + 32'h400C, 32'hFFFF_FFFF, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
